// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA CRT decryption engine: FSM encodings,
// default prime width and the closed-form start-to-finish latency.
package rsa_pkg;

  localparam int RSA_WIDTH = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RED_P,
    ST_EXP_P,
    ST_RED_Q,
    ST_EXP_Q,
    ST_SUB,
    ST_MUL_H,
    ST_RECOMB,
    ST_DONE
  } crt_state_e;

  typedef enum logic {
    PH_SQ,
    PH_MUL
  } exp_phase_e;

  function automatic int crt_latency(input int w);
    return 4 * w * w + 10 * w + 6;
  endfunction

endpackage

// File: rtl/rsa_crt_decrypt_if.sv
// Start/finish handshake and operand bundle for the CRT decryption engine.
interface rsa_crt_decrypt_if import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH
);

  logic                 start;
  logic [2*WIDTH-1:0]   ciphertext;
  logic [WIDTH-1:0]     p;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     dp;
  logic [WIDTH-1:0]     dq;
  logic [WIDTH-1:0]     qinv;
  logic                 busy;
  logic                 finish;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, ciphertext, p, q, dp, dq, qinv,
    input  busy, finish, result
  );

  modport slave (
    input  start, ciphertext, p, q, dp, dq, qinv,
    output busy, finish, result
  );

endinterface

// File: rtl/mod_mul_seq.sv
// Sequential interleaved shift-add modular multiplier: one load cycle, then
// one bit of b per cycle (WIDTH bits, or 2*WIDTH when wide is set).
module mod_mul_seq import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               nomod,
  input  logic               wide,
  input  logic [WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] r,
  output logic               done
);

  localparam int CW = $clog2(2 * WIDTH) + 1;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] b_q, b_d;
  logic [2*WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               nomod_q, nomod_d;
  logic               wide_q, wide_d;

  logic [CW-1:0]      last;
  logic [WIDTH+1:0]   m_ext, addend, t0, t1, t2;
  logic [2*WIDTH-1:0] prod;

  // 2r+a < 3m when r,a < m, so two conditional subtracts restore r < m
  always_comb begin
    last   = wide_q ? CW'(2 * WIDTH - 1) : CW'(WIDTH - 1);
    m_ext  = {2'b00, m_q};
    addend = b_q[2*WIDTH-1] ? {2'b00, a_q} : '0;
    t0     = {1'b0, r_q[WIDTH-1:0], 1'b0} + addend;
    t1     = (t0 >= m_ext) ? t0 - m_ext : t0;
    t2     = (t1 >= m_ext) ? t1 - m_ext : t1;
    prod   = {r_q[2*WIDTH-2:0], 1'b0} +
             (b_q[2*WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);

    a_d     = a_q;
    m_d     = m_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    nomod_d = nomod_q;
    wide_d  = wide_q;

    if (load) begin
      a_d     = a;
      m_d     = m;
      b_d     = wide ? b : {b[WIDTH-1:0], {WIDTH{1'b0}}};
      r_d     = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
      nomod_d = nomod;
      wide_d  = wide;
    end else if (run_q) begin
      r_d   = nomod_q ? prod : (2 * WIDTH)'(t2);
      b_d   = {b_q[2*WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == last) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      m_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      nomod_q <= 1'b0;
      wide_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      m_q     <= m_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      nomod_q <= nomod_d;
      wide_q  <= wide_d;
    end
  end

  assign r    = r_q;
  assign done = run_q && (cnt_q == last);

endmodule

// File: rtl/rsa_crt_decrypt.sv
// RSA CRT decryption m = c^d mod pq, sequenced over one shared modular
// multiplier with operand-independent latency.
module rsa_crt_decrypt import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  rsa_crt_decrypt_if.slave   bus
);

  localparam int BW = $clog2(WIDTH);

  crt_state_e         state_q, state_d;
  exp_phase_e         phase_q, phase_d;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0]   p_q, p_d, q_q, q_d;
  logic [WIDTH-1:0]   dp_q, dp_d, dq_q, dq_d, qinv_q, qinv_d;
  logic [WIDTH-1:0]   e_q, e_d, base_q, base_d, sq_q, sq_d;
  logic [WIDTH-1:0]   m1_q, m1_d, m2_q, m2_d, d_q, d_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               keep_q, keep_d, ld_q, ld_d, add_q, add_d;
  logic               busy_q, busy_d, finish_q, finish_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               mm_load, mm_nomod, mm_wide, mm_done;
  logic [WIDTH-1:0]   mm_a, mm_m;
  logic [2*WIDTH-1:0] mm_b, mm_r;
  logic [WIDTH-1:0]   acc_cur, cur_mod;

  mod_mul_seq #(.WIDTH(WIDTH)) u_mm (
    .clk   (clk),
    .reset (reset),
    .load  (mm_load),
    .nomod (mm_nomod),
    .wide  (mm_wide),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mm_m),
    .r     (mm_r),
    .done  (mm_done)
  );

  // The accumulator is never stored: it is the last multiply result when
  // that exponent bit was 1, otherwise the saved square.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    c_d       = c_q;
    p_d       = p_q;
    q_d       = q_q;
    dp_d      = dp_q;
    dq_d      = dq_q;
    qinv_d    = qinv_q;
    e_d       = e_q;
    base_d    = base_q;
    sq_d      = sq_q;
    keep_d    = keep_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    d_d       = d_q;
    bit_cnt_d = bit_cnt_q;
    ld_d      = 1'b0;
    add_d     = add_q;
    busy_d    = busy_q;
    finish_d  = finish_q;
    result_d  = result_q;

    mm_load   = 1'b0;
    mm_nomod  = 1'b0;
    mm_wide   = 1'b0;
    mm_a      = '0;
    mm_b      = '0;
    mm_m      = '0;

    acc_cur = keep_q ? mm_r[WIDTH-1:0] : sq_q;
    cur_mod = (state_q == ST_RED_P || state_q == ST_EXP_P) ? p_q : q_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          c_d      = bus.ciphertext;
          p_d      = bus.p;
          q_d      = bus.q;
          dp_d     = bus.dp;
          dq_d     = bus.dq;
          qinv_d   = bus.qinv;
          busy_d   = 1'b1;
          finish_d = 1'b0;
          ld_d     = 1'b1;
          state_d  = ST_RED_P;
        end
      end

      ST_RED_P, ST_RED_Q: begin
        mm_load = ld_q;
        mm_a    = WIDTH'(1);
        mm_b    = c_q;
        mm_m    = cur_mod;
        mm_wide = 1'b1;
        if (ld_q && state_q == ST_RED_Q) begin
          m1_d = acc_cur;
        end
        if (mm_done) begin
          ld_d      = 1'b1;
          sq_d      = WIDTH'(1);
          keep_d    = 1'b0;
          bit_cnt_d = '0;
          phase_d   = PH_SQ;
          e_d       = (state_q == ST_RED_P) ? dp_q : dq_q;
          state_d   = (state_q == ST_RED_P) ? ST_EXP_P : ST_EXP_Q;
        end
      end

      ST_EXP_P, ST_EXP_Q: begin
        mm_load = ld_q;
        mm_m    = cur_mod;
        if (phase_q == PH_SQ) begin
          mm_a = acc_cur;
          mm_b = {{WIDTH{1'b0}}, acc_cur};
          if (ld_q && bit_cnt_q == '0) begin
            base_d = mm_r[WIDTH-1:0];
          end
        end else begin
          mm_a = base_q;
          mm_b = {{WIDTH{1'b0}}, mm_r[WIDTH-1:0]};
          if (ld_q) begin
            sq_d = mm_r[WIDTH-1:0];
          end
        end
        if (mm_done) begin
          ld_d = 1'b1;
          if (phase_q == PH_SQ) begin
            phase_d = PH_MUL;
          end else begin
            phase_d = PH_SQ;
            keep_d  = e_q[WIDTH-1];
            e_d     = {e_q[WIDTH-2:0], 1'b0};
            if (bit_cnt_q == BW'(WIDTH - 1)) begin
              state_d = (state_q == ST_EXP_P) ? ST_RED_Q : ST_SUB;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end

      // m2 < q < p, so a single +p brings a negative difference into range
      ST_SUB: begin
        m2_d    = acc_cur;
        d_d     = m1_q - acc_cur + ((m1_q >= acc_cur) ? '0 : p_q);
        ld_d    = 1'b1;
        state_d = ST_MUL_H;
      end

      ST_MUL_H: begin
        mm_load = ld_q;
        mm_a    = qinv_q;
        mm_b    = {{WIDTH{1'b0}}, d_q};
        mm_m    = p_q;
        if (mm_done) begin
          ld_d    = 1'b1;
          state_d = ST_RECOMB;
        end
      end

      ST_RECOMB: begin
        if (!add_q) begin
          mm_load  = ld_q;
          mm_nomod = 1'b1;
          mm_a     = q_q;
          mm_b     = {{WIDTH{1'b0}}, mm_r[WIDTH-1:0]};
          mm_m     = p_q;
          if (mm_done) begin
            add_d = 1'b1;
          end
        end else begin
          result_d = {{WIDTH{1'b0}}, m2_q} + mm_r;
          add_d    = 1'b0;
          busy_d   = 1'b0;
          finish_d = 1'b1;
          state_d  = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_SQ;
      c_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      dp_q      <= '0;
      dq_q      <= '0;
      qinv_q    <= '0;
      e_q       <= '0;
      base_q    <= '0;
      sq_q      <= '0;
      keep_q    <= 1'b0;
      m1_q      <= '0;
      m2_q      <= '0;
      d_q       <= '0;
      bit_cnt_q <= '0;
      ld_q      <= 1'b0;
      add_q     <= 1'b0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      c_q       <= c_d;
      p_q       <= p_d;
      q_q       <= q_d;
      dp_q      <= dp_d;
      dq_q      <= dq_d;
      qinv_q    <= qinv_d;
      e_q       <= e_d;
      base_q    <= base_d;
      sq_q      <= sq_d;
      keep_q    <= keep_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      d_q       <= d_d;
      bit_cnt_q <= bit_cnt_d;
      ld_q      <= ld_d;
      add_q     <= add_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.finish = finish_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Scoreboard bench for rsa_crt_decrypt: directed 8-bit vectors plus 32-bit
// vectors built from an independent big-integer RSA model.
module tb_rsa_crt_decrypt;
  import rsa_pkg::*;

  typedef struct {
    logic [63:0] result;
    int          stamp;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp8[$];
  exp_t exp32[$];
  bit   prev8;
  bit   prev32;

  rsa_crt_decrypt_if #(.WIDTH(8))  bus8();
  rsa_crt_decrypt_if #(.WIDTH(32)) bus32();

  rsa_crt_decrypt #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  rsa_crt_decrypt #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] n);
    logic [127:0] t;
    t = {64'd0, a} * {64'd0, b};
    t = t % {64'd0, n};
    return t[63:0];
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] base, input logic [63:0] e, input logic [63:0] n);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd1 % n;
    b = base % n;
    for (int i = 63; i >= 0; i--) begin
      r = mulmod(r, r, n);
      if (e[i]) r = mulmod(r, b, n);
    end
    return r;
  endfunction

  function automatic longint modinv(input longint a, input longint m);
    longint t, newt, r, newr, qt, tmp;
    t = 0; newt = 1; r = m; newr = a;
    while (newr != 0) begin
      qt   = r / newr;
      tmp  = t - qt * newt; t = newt; newt = tmp;
      tmp  = r - qt * newr; r = newr; newr = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

  task automatic applyStimulus(input bit big, input logic [63:0] c, input logic [63:0] expm);
    exp_t e;
    @(negedge clk);
    if (big) begin
      bus32.ciphertext = c;
      bus32.start = 1'b1;
    end else begin
      bus8.ciphertext = c[15:0];
      bus8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus8.start  = 1'b0;
    bus32.start = 1'b0;
    e.result = expm;
    e.stamp  = cyc;
    if (big) begin
      exp32.push_back(e);
      checkOutput("busy_after_start32", 64'(bus32.busy), 64'd1);
      checkOutput("finish_cleared32", 64'(bus32.finish), 64'd0);
    end else begin
      exp8.push_back(e);
      checkOutput("busy_after_start8", 64'(bus8.busy), 64'd1);
      checkOutput("finish_cleared8", 64'(bus8.finish), 64'd0);
    end
  endtask

  task automatic waitFinish(input bit big);
    int n;
    int limit;
    logic fin;
    n = 0;
    limit = crt_latency(big ? 32 : 8) + 20;
    fin = big ? bus32.finish : bus8.finish;
    while (!fin && n < limit) begin
      @(negedge clk);
      n++;
      fin = big ? bus32.finish : bus8.finish;
    end
    checkOutput(big ? "done_in_time32" : "done_in_time8", 64'(fin), 64'd1);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares each rising finish against the oldest expectation.
  initial begin
    exp_t e;
    prev8 = 1'b0;
    prev32 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus8.finish && !prev8) begin
        if (exp8.size() == 0) begin
          checkOutput("sb_unexpected8", 64'd0, 64'd1);
        end else begin
          e = exp8.pop_front();
          checkOutput("result8", 64'(bus8.result), e.result);
          checkOutput("latency8", 64'(cyc - e.stamp), 64'd342);
          checkOutput("busy_at_finish8", 64'(bus8.busy), 64'd0);
        end
      end
      if (!reset && bus32.finish && !prev32) begin
        if (exp32.size() == 0) begin
          checkOutput("sb_unexpected32", 64'd0, 64'd1);
        end else begin
          e = exp32.pop_front();
          checkOutput("result32", bus32.result, e.result);
          checkOutput("latency32", 64'(cyc - e.stamp), 64'd4422);
          checkOutput("busy_at_finish32", 64'(bus32.busy), 64'd0);
        end
      end
      prev8  = bus8.finish;
      prev32 = bus32.finish;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] p32, q32, n32, m, c;
    cyc = 0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus8.start = 1'b0;  bus8.ciphertext = '0;
    bus8.p = 8'd13; bus8.q = 8'd11; bus8.dp = 8'd7; bus8.dq = 8'd3; bus8.qinv = 8'd6;
    bus32.start = 1'b0; bus32.ciphertext = '0;
    bus32.p = '0; bus32.q = '0; bus32.dp = '0; bus32.dq = '0; bus32.qinv = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy8", 64'(bus8.busy), 64'd0);
    checkOutput("reset_finish8", 64'(bus8.finish), 64'd0);
    checkOutput("reset_result8", 64'(bus8.result), 64'd0);
    checkOutput("reset_busy32", 64'(bus32.busy), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed 8-bit vectors: p=13 q=11 dp=7 dq=3 qinv=6
    applyStimulus(1'b0, 64'd47, 64'd5);   waitFinish(1'b0);
    applyStimulus(1'b0, 64'd14, 64'd27);  waitFinish(1'b0);
    applyStimulus(1'b0, 64'd142, 64'd142); waitFinish(1'b0);
    applyStimulus(1'b0, 64'd0, 64'd0);    waitFinish(1'b0);
    applyStimulus(1'b0, 64'd1, 64'd1);    waitFinish(1'b0);

    // Second start mid-run must be ignored
    applyStimulus(1'b0, 64'd47, 64'd5);
    repeat (98) @(negedge clk);
    bus8.ciphertext = 16'd14;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.ciphertext = 16'd47;
    waitFinish(1'b0);
    repeat (5) @(negedge clk);
    checkOutput("finish_held8", 64'(bus8.finish), 64'd1);
    checkOutput("idle_after_done8", 64'(bus8.busy), 64'd0);
    checkOutput("result_held8", 64'(bus8.result), 64'd5);

    // Abort mid-EXP_Q with reset, then a clean run
    applyStimulus(1'b0, 64'd14, 64'd27);
    repeat (250) @(negedge clk);
    reset = 1'b1;
    exp8.delete();
    #1;
    checkOutput("abort_busy8", 64'(bus8.busy), 64'd0);
    checkOutput("abort_finish8", 64'(bus8.finish), 64'd0);
    checkOutput("abort_result8", 64'(bus8.result), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("abort_hold_busy8", 64'(bus8.busy), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 64'd47, 64'd5);   waitFinish(1'b0);

    // 32-bit primes; ciphertexts made with e=65537 by the reference model
    p32 = 64'd4294967291;
    q32 = 64'd2147483647;
    n32 = p32 * q32;
    bus32.p    = p32[31:0];
    bus32.q    = q32[31:0];
    bus32.dp   = 32'(modinv(longint'(65537), longint'(p32 - 64'd1)));
    bus32.dq   = 32'(modinv(longint'(65537), longint'(q32 - 64'd1)));
    m = powmod(q32, p32 - 64'd2, p32);
    bus32.qinv = m[31:0];
    for (int i = 0; i < 3; i++) begin
      if (i == 0) m = 64'd2;
      else m = {$urandom(), $urandom()} % n32;
      c = powmod(m, 64'd65537, n32);
      applyStimulus(1'b1, c, m);
      waitFinish(1'b1);
    end

    checkOutput("sb_drain8", 64'(exp8.size()), 64'd0);
    checkOutput("sb_drain32", 64'(exp32.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
